pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

- Parametrised hazard and sequencing controller for the 5-stage RSA pipelined CPU (Fetch/Decode/Execute/Memory/Writeback).
- Covers what the previous generation lacked:
  - `start`-gated run/halt sequencing with pipeline drain.
  - Forwarding and load-use stall detection.
  - Branch flush.
  - A parametrised multi-cycle Execute stall for the modular-multiply unit.
- Sits beside `control_unit` inside the core wrapper and drives the stall/flush/forward inputs of `datapath`.

## Interface
Parameters:
- `REG_AW`, 4, register address width.
- `PC_REG`, 15, register index never forwarded (PC).
- `NSTAGES`, 5, pipeline depth; drain length is derived from it.
- `MUL_LAT`, 4, Execute cycles for a multiply; must be ≥1.

Ports:
- `clk`  in  1  core clock.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  single-cycle pulse; leaves IDLE or HALT.
- `halt_req`  in  1  halt instruction is in Decode.
- `Ra1D`, `Ra2D`  in  REG_AW  Decode source registers.
- `Ra1E`, `Ra2E`  in  REG_AW  Execute source registers.
- `WA3E`, `WA3M`, `WA3W`  in  REG_AW  destination registers per stage.
- `RegWriteM`, `RegWriteW`  in  1  write enables.
- `MemtoRegE`  in  1  Execute instruction is a load.
- `BranchTakenE`  in  1  taken branch resolved in Execute.
- `MulStartE`  in  1  Execute instruction is a multiply (held while it stays in E).
- `ForwardAE`, `ForwardBE`  out  2  00 = register file, 01 = Writeback result, 10 = Memory ALU result.
- `StallF`, `StallD`, `StallE`  out  1  hold stage registers.
- `FlushD`, `FlushE`, `FlushM`  out  1  insert a bubble.
- `running`  out  1  FSM in RUN or DRAIN.
- `halted`  out  1  FSM in HALT.

## Operation
FSM states: IDLE, RUN, DRAIN, HALT.
- Reset value: IDLE.
- IDLE → RUN on `start`.
- RUN → DRAIN on `halt_req` when not stalled.
- DRAIN → HALT after `NSTAGES-2` non-stalled cycles.
- HALT → RUN on `start`.
- `start` is ignored in RUN and DRAIN.

IDLE and HALT:
- `StallF`=`StallD`=1, `FlushE`=1.
- Forward outputs 00; all other outputs 0.

DRAIN:
- `StallF`=1, `FlushD`=1; no new fetch.
- Drain counter decrements only on cycles with `StallE`=0.

Forwarding (combinational), per source X∈{1,2}:
- Select 10 if `RegWriteM` && `WA3M`==`RaXE` && `RaXE`≠`PC_REG`.
- Otherwise 01 if the same test passes for W.
- Otherwise 00.
- M has priority over W.

Load-use stall `ldstall` = `MemtoRegE` && (`WA3E`==`Ra1D` || `WA3E`==`Ra2D`).
- Effect: `StallF`=`StallD`=1 and `FlushE`=1.
- Suppressed when `BranchTakenE`=1.

Branch: `BranchTakenE` forces `FlushD`=`FlushE`=1.

Multiply stall:
- Registered `mul_active` and a down-counter `cnt` of width $clog2(MUL_LAT).
- `mulbusy` = `MulStartE` && (!`mul_active` || `cnt`≠0), forced to 0 when `MUL_LAT`==1.
- Counter loading: when `MulStartE` && !`mul_active`, load `cnt`=`MUL_LAT-2` and set `mul_active`.
- While `cnt`≠0, decrement `cnt`.
- Clear `mul_active` when `cnt`==0 && `mul_active`.
- `mulbusy` effect: `StallF`=`StallD`=`StallE`=1 and `FlushM`=1.

Priority, highest first:
1. FSM idle/halt.
2. `mulbusy` (overrides branch and load-use; decode guarantees a multiply never signals a branch).
3. `BranchTakenE`.
4. `ldstall`.

Reset:
- Clears the FSM, `cnt`, `mul_active` and the drain counter in the same edge, including mid-multiply and mid-drain.

## Timing
- Forward, stall and flush outputs are combinational from inputs and registered state, with no extra latency.
- `running` and `halted` are registered.
- A multiply entering E at cycle t is stalled for cycles t..t+MUL_LAT-2 and leaves E at the end of cycle t+MUL_LAT-1, i.e. `MUL_LAT-1` stall cycles.
- `MulStartE` still high in cycle t+MUL_LAT-1 must not retrigger the multiply stall.
- A load-use stall lasts exactly 1 cycle.
- `start` in cycle t gives `running`=1 from t+1.
- `halt_req` accepted in cycle t gives `halted`=1 at cycle t+1+(NSTAGES-2), plus any multiply stall cycles.

## Structure
- Package `pipe_pkg`:
  - `fwd_sel_t` enum (`FWD_RF`, `FWD_WB`, `FWD_MEM`).
  - `core_state_t` enum (`IDLE`, `RUN`, `DRAIN`, `HALT`).
- One sub-module, `mul_stall_ctr`, containing the multiply counter and `mul_active`, parametrised by `MUL_LAT`, with output `mulbusy`.

## Test plan
- Reset low 2 cycles, then high with no `start` → IDLE, `StallF`=1, `FlushE`=1, `running`=0; `start` pulse → `running`=1 next cycle.
- `RegWriteM`=1, `WA3M`=3, `RegWriteW`=1, `WA3W`=3, `Ra1E`=3 → `ForwardAE`=10. With `Ra1E`=15 and both destinations 15 → 00.
- `MemtoRegE`=1, `WA3E`=5, `Ra2D`=5 → one cycle with `StallF`=`StallD`=`FlushE`=1. Same with `BranchTakenE`=1 → only `FlushD`=`FlushE`=1.
- `MUL_LAT`=4, `MulStartE` held 4 cycles → `StallE`=`FlushM`=1 for exactly 3 cycles, 0 on the 4th. With `MUL_LAT`=1 → never stalls.
- `halt_req` in RUN → DRAIN with `StallF`=`FlushD`=1; `halted`=1 after 3 cycles, 6 if a `MUL_LAT`=4 multiply is in E. Then `start` → RUN.
- Reset asserted mid-multiply (`cnt`=1) → next cycle IDLE, `mul_active`=0, `StallE`=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types for the pipeline hazard/sequencing controller
package pipe_pkg;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALT} core_state_t;
endpackage

// File: rtl/mul_stall_ctr.sv
// mul_stall_ctr: holds a multiply in Execute for MUL_LAT-1 cycles
module mul_stall_ctr #(
  parameter int MUL_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic mul_start,
  output logic mulbusy
);
  localparam int CW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
  localparam logic [CW-1:0] LOAD = CW'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
  logic [CW-1:0] cnt;
  logic mul_active;
  // the final cycle (cnt==0 with mul_active) releases E even while mul_start is still high
  assign mulbusy = (MUL_LAT > 1) && mul_start && (!mul_active || cnt != '0);
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
      mul_active <= 1'b0;
    end else if (mul_start && !mul_active) begin
      cnt <= LOAD;
      mul_active <= 1'b1;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end else if (mul_active) begin
      mul_active <= 1'b0;
    end
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: run/halt sequencing, forwarding, stall and flush control for the 5-stage core
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW  = 4,
  parameter int PC_REG  = 15,
  parameter int NSTAGES = 5,
  parameter int MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt_req,
  input  logic [REG_AW-1:0] Ra1D,
  input  logic [REG_AW-1:0] Ra2D,
  input  logic [REG_AW-1:0] Ra1E,
  input  logic [REG_AW-1:0] Ra2E,
  input  logic [REG_AW-1:0] WA3E,
  input  logic [REG_AW-1:0] WA3M,
  input  logic [REG_AW-1:0] WA3W,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              BranchTakenE,
  input  logic              MulStartE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              running,
  output logic              halted
);
  localparam logic [REG_AW-1:0] PC = REG_AW'(PC_REG);
  localparam int DW = $clog2(NSTAGES);
  localparam logic [DW-1:0] DRAIN_N = DW'(NSTAGES - 2);
  core_state_t state, next;
  logic [DW-1:0] dcnt, dcnt_n;
  logic mulbusy, ldstall, idle, drain;
  function automatic logic hit(input logic we, input logic [REG_AW-1:0] wa, input logic [REG_AW-1:0] ra);
    return we && wa == ra && ra != PC;
  endfunction
  mul_stall_ctr #(.MUL_LAT(MUL_LAT)) u_mul (
    .clk(clk),
    .reset(reset),
    .mul_start(MulStartE),
    .mulbusy(mulbusy)
  );
  assign idle = state == IDLE || state == HALT;
  assign drain = state == DRAIN;
  assign ldstall = MemtoRegE && (WA3E == Ra1D || WA3E == Ra2D) && !BranchTakenE;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      dcnt <= '0;
      running <= 1'b0;
      halted <= 1'b0;
    end else begin
      state <= next;
      dcnt <= dcnt_n;
      running <= next == RUN || next == DRAIN;
      halted <= next == HALT;
    end
  end
  always_comb begin
    next = state;
    dcnt_n = dcnt;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    StallF = 1'b1;
    StallD = 1'b1;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b1;
    FlushM = 1'b0;
    if (idle) begin
      next = start ? RUN : state;
    end else begin
      ForwardAE = hit(RegWriteM, WA3M, Ra1E) ? FWD_MEM : hit(RegWriteW, WA3W, Ra1E) ? FWD_WB : FWD_RF;
      ForwardBE = hit(RegWriteM, WA3M, Ra2E) ? FWD_MEM : hit(RegWriteW, WA3W, Ra2E) ? FWD_WB : FWD_RF;
      StallE = mulbusy;
      FlushM = mulbusy;
      StallD = mulbusy || ldstall;
      StallF = mulbusy || ldstall || drain;
      FlushE = !mulbusy && (BranchTakenE || ldstall);
      FlushD = drain || (!mulbusy && BranchTakenE);
      if (state == RUN && halt_req && !StallD) begin
        next = DRAIN;
        dcnt_n = DRAIN_N;
      end
      // drain only advances when Execute moves, so multiply stalls extend it
      if (drain && !StallE) begin
        dcnt_n = dcnt - DW'(1);
        next = (dcnt == DW'(1)) ? HALT : DRAIN;
      end
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for pipe_hazard_ctrl (MUL_LAT=4 and MUL_LAT=1 instances)
module tb_pipe_hazard_ctrl;
  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic [7:0] f;
  } vec_t;
  // f = {StallF,StallD,StallE, FlushD,FlushE,FlushM, running,halted}
  localparam logic [7:0] IDL = 8'b110_010_00, RN = 8'b000_000_10, LD = 8'b110_010_10,
                         BR = 8'b000_110_10, ML = 8'b111_001_10, DR = 8'b100_100_10,
                         DM = 8'b111_101_10, HL = 8'b110_010_01;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, halt_req = 1'b0;
  logic [3:0] Ra1D = '0, Ra2D = '0, Ra1E = '0, Ra2E = '0, WA3E = '0, WA3M = '0, WA3W = '0;
  logic RegWriteM = 1'b0, RegWriteW = 1'b0, MemtoRegE = 1'b0, BranchTakenE = 1'b0, MulStartE = 1'b0;
  logic [1:0] ForwardAE, ForwardBE, fa1, fb1;
  logic StallF, StallD, StallE, FlushD, FlushE, FlushM, running, halted;
  logic sf1, sd1, se1, fd1, fe1, fm1, run1, hlt1;
  vec_t q[$], q1[$];
  string qn[$];
  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MUL_LAT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
    .Ra1D(Ra1D), .Ra2D(Ra2D), .Ra1E(Ra1E), .Ra2E(Ra2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .BranchTakenE(BranchTakenE), .MulStartE(MulStartE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .running(running), .halted(halted)
  );

  pipe_hazard_ctrl #(.MUL_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
    .Ra1D(Ra1D), .Ra2D(Ra2D), .Ra1E(Ra1E), .Ra2E(Ra2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .BranchTakenE(BranchTakenE), .MulStartE(MulStartE),
    .ForwardAE(fa1), .ForwardBE(fb1),
    .StallF(sf1), .StallD(sd1), .StallE(se1),
    .FlushD(fd1), .FlushE(fe1), .FlushM(fm1),
    .running(run1), .halted(hlt1)
  );

  function automatic vec_t obs();
    return vec_t'({ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, running, halted});
  endfunction

  function automatic vec_t obs1();
    return vec_t'({fa1, fb1, sf1, sd1, se1, fd1, fe1, fm1, run1, hlt1});
  endfunction

  task automatic clr();
    start = 0; halt_req = 0; Ra1D = 0; Ra2D = 0; Ra1E = 0; Ra2E = 0;
    WA3E = 0; WA3M = 0; WA3W = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; BranchTakenE = 0; MulStartE = 0;
  endtask

  task automatic test_reset();
    vec_t e;
    string n;
    logic [7:0] ef[6] = '{IDL, IDL, IDL, IDL, IDL, RN};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      clr();
      reset = (i >= 2);
      start = (i == 4);
      q.push_back(vec_t'({4'b0000, ef[i]}));
      qn.push_back($sformatf("reset_seq%0d", i));
      @(negedge clk);
      e = q.pop_front(); n = qn.pop_front();
      checks++;
      if (obs() !== e) begin fails++; $display("FAIL %s: got %b expected %b", n, obs(), e); end
    end
  endtask

  task automatic test_forward();
    vec_t e;
    string n;
    int wm[5] = '{1, 1, 0, 1, 0}, am[5] = '{3, 15, 0, 9, 4}, ww[5] = '{1, 1, 1, 1, 0};
    int aw[5] = '{3, 15, 7, 2, 4}, r1[5] = '{3, 15, 7, 2, 4}, r2[5] = '{0, 15, 7, 9, 4};
    int ea[5] = '{2, 0, 1, 1, 0}, eb[5] = '{0, 0, 1, 2, 0};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      clr();
      RegWriteM = 1'(wm[i]); WA3M = 4'(am[i]); RegWriteW = 1'(ww[i]); WA3W = 4'(aw[i]);
      Ra1E = 4'(r1[i]); Ra2E = 4'(r2[i]);
      start = (i == 4);
      q.push_back(vec_t'({2'(ea[i]), 2'(eb[i]), RN}));
      qn.push_back($sformatf("forward%0d", i));
      @(negedge clk);
      e = q.pop_front(); n = qn.pop_front();
      checks++;
      if (obs() !== e) begin fails++; $display("FAIL %s: got %b expected %b", n, obs(), e); end
    end
  endtask

  task automatic test_ldstall();
    vec_t e;
    string n;
    int mt[7] = '{1, 0, 1, 0, 1, 1, 0}, we[7] = '{5, 0, 6, 0, 5, 5, 0};
    int d1[7] = '{0, 0, 6, 0, 0, 0, 0}, d2[7] = '{5, 0, 0, 0, 5, 4, 0}, bt[7] = '{0, 0, 0, 0, 1, 0, 1};
    logic [7:0] ef[7] = '{LD, RN, LD, RN, BR, RN, BR};
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      clr();
      MemtoRegE = 1'(mt[i]); WA3E = 4'(we[i]); Ra1D = 4'(d1[i]); Ra2D = 4'(d2[i]); BranchTakenE = 1'(bt[i]);
      q.push_back(vec_t'({4'b0000, ef[i]}));
      qn.push_back($sformatf("ldstall%0d", i));
      @(negedge clk);
      e = q.pop_front(); n = qn.pop_front();
      checks++;
      if (obs() !== e) begin fails++; $display("FAIL %s: got %b expected %b", n, obs(), e); end
    end
  endtask

  task automatic test_back_to_back_mul();
    vec_t e, e1;
    string n;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      clr();
      MulStartE = (i < 8);
      BranchTakenE = (i == 4);
      q.push_back(vec_t'({4'b0000, (i < 8 && i % 4 != 3) ? ML : (i == 4) ? BR : RN}));
      q1.push_back(vec_t'({4'b0000, (i == 4) ? BR : RN}));
      qn.push_back($sformatf("mul%0d", i));
      @(negedge clk);
      e = q.pop_front(); e1 = q1.pop_front(); n = qn.pop_front();
      checks++;
      if (obs() !== e) begin fails++; $display("FAIL %s lat4: got %b expected %b", n, obs(), e); end
      checks++;
      if (obs1() !== e1) begin fails++; $display("FAIL %s lat1: got %b expected %b", n, obs1(), e1); end
    end
  endtask

  task automatic test_halt();
    vec_t e;
    string n;
    logic [7:0] ef[8] = '{LD, RN, DR, DR, DR, HL, HL, RN};
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      clr();
      halt_req = (i < 2);
      MemtoRegE = (i == 0); WA3E = 4'd5; Ra1D = 4'd5;
      start = (i == 6);
      q.push_back(vec_t'({4'b0000, ef[i]}));
      qn.push_back($sformatf("halt%0d", i));
      @(negedge clk);
      e = q.pop_front(); n = qn.pop_front();
      checks++;
      if (obs() !== e) begin fails++; $display("FAIL %s: got %b expected %b", n, obs(), e); end
    end
  endtask

  task automatic test_halt_mul();
    vec_t e;
    string n;
    logic [7:0] ef[10] = '{RN, DM, DM, DM, DR, DR, DR, HL, HL, RN};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      clr();
      halt_req = (i == 0);
      MulStartE = (i >= 1 && i <= 4);
      start = (i == 8);
      q.push_back(vec_t'({4'b0000, ef[i]}));
      qn.push_back($sformatf("halt_mul%0d", i));
      @(negedge clk);
      e = q.pop_front(); n = qn.pop_front();
      checks++;
      if (obs() !== e) begin fails++; $display("FAIL %s: got %b expected %b", n, obs(), e); end
    end
  endtask

  task automatic test_reset_mid();
    vec_t e;
    string n;
    logic [7:0] ef[14] = '{ML, ML, RN, IDL, IDL, ML, ML, ML, RN, RN, RN, DR, DR, IDL};
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      clr();
      reset = !(i == 2 || i == 12);
      MulStartE = (i < 2) || (i >= 5 && i <= 8);
      start = (i == 4);
      halt_req = (i == 10);
      q.push_back(vec_t'({4'b0000, ef[i]}));
      qn.push_back($sformatf("reset_mid%0d", i));
      @(negedge clk);
      e = q.pop_front(); n = qn.pop_front();
      checks++;
      if (obs() !== e) begin fails++; $display("FAIL %s: got %b expected %b", n, obs(), e); end
      if (ef[i] == IDL) begin
        checks++;
        if (obs1() !== e) begin fails++; $display("FAIL %s lat1: got %b expected %b", n, obs1(), e); end
      end
      if (i == 3) begin
        checks++;
        if (dut.u_mul.mul_active !== 1'b0) begin
          fails++; $display("FAIL mul_active_after_reset: got %b expected 0", dut.u_mul.mul_active);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_forward();
    test_ldstall();
    test_back_to_back_mul();
    test_halt();
    test_halt_mul();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
